// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage register.
// Optional feature macro used by pipe_stage_reg: PIPE_REG_SKID_EN
// (adds a second "skid" slot and makes in_ready a pure register output).

package pipe_pkg;

    // Occupancy states of one pipeline stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    // Default widths of the stage fields.
    localparam int DATA_W_DEF = 64;
    localparam int RD_W_DEF   = 5;
    localparam int CTRL_W_DEF = 8;

    // MIPS control bundle carried alongside each beat.
    // Instances carrying this bundle use CTRL_W = $bits(ctrl_t).
    typedef struct packed {
        logic jump;
        logic branch;
        logic alu_src;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic reg_dst;
        logic mem_to_reg;
    } ctrl_t;

    // Number of beats held by the stage in a given state.
    function automatic logic [1:0] beat_count(input pipe_state_e s);
        logic [1:0] n;
        case (s)
            EMPTY:   n = 2'd0;
            FULL:    n = 2'd1;
            SKID:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline stage: a valid flag plus an opaque payload.
// The payload is zeroed whenever the slot is cleared or reset, so an empty
// slot always presents an all-zero payload (bubble).

module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_data,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_r;
    logic [W-1:0] data_r;

    // Slot register: reset and clear dominate load; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (clear) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, flush and bubble
// zeroing. Outputs always come straight from the main slot register.
// Optional macro PIPE_REG_SKID_EN: adds a skid slot (two beats of buffering)
// and registers in_ready, cutting the ready path from out_ready to in_ready.
// Without it the stage is a single slot and in_ready = !out_valid | out_ready.

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [CTRL_W-1:0] out_ctrl
);

    localparam int PW = DATA_W + RD_W + CTRL_W;

    pipe_state_e state_r;
    pipe_state_e state_nxt_s;

    logic          in_xfer_s;
    logic          out_xfer_s;
    logic          in_ready_s;
    logic [PW-1:0] in_payload_s;

    logic          main_load_s;
    logic          main_clear_s;
    logic [PW-1:0] main_din_s;
    logic          main_valid_s;
    logic [PW-1:0] main_data_s;

`ifdef PIPE_REG_SKID_EN
    logic          in_ready_r;
    logic          main_from_skid_s;
    logic          skid_load_s;
    logic          skid_clear_s;
    logic          skid_valid_s;
    logic [PW-1:0] skid_data_s;
`endif

    assign in_payload_s = {in_data, in_rd, in_ctrl};

`ifdef PIPE_REG_SKID_EN
    // Ready is a flop: the stage can accept as long as the skid slot is free.
    assign in_ready_s = in_ready_r;
`else
    // Single slot: accept when empty, or when the held beat leaves this cycle.
    assign in_ready_s = ~main_valid_s | out_ready;
`endif

    assign in_xfer_s  = in_valid & in_ready_s;
    assign out_xfer_s = main_valid_s & out_ready;

    // Next-state and slot-control decode from the current occupancy.
    always_comb begin
        state_nxt_s      = state_r;
        main_load_s      = 1'b0;
        main_clear_s     = 1'b0;
`ifdef PIPE_REG_SKID_EN
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_clear_s     = 1'b0;
`endif
        if (flush) begin
            // Squash: everything held (and any incoming beat) is dropped.
            // A beat taken downstream this same cycle is simply not repeated.
            state_nxt_s  = EMPTY;
            main_clear_s = 1'b1;
`ifdef PIPE_REG_SKID_EN
            skid_clear_s = 1'b1;
`endif
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_xfer_s) begin
                        state_nxt_s = FULL;
                        main_load_s = 1'b1;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                FULL: begin
                    if (in_xfer_s && out_xfer_s) begin
                        state_nxt_s = FULL;
                        main_load_s = 1'b1;
                    end else if (out_xfer_s) begin
                        state_nxt_s  = EMPTY;
                        main_clear_s = 1'b1;
`ifdef PIPE_REG_SKID_EN
                    end else if (in_xfer_s) begin
                        // Downstream stalled: park the new beat behind main.
                        state_nxt_s = SKID;
                        skid_load_s = 1'b1;
`endif
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
`ifdef PIPE_REG_SKID_EN
                SKID: begin
                    // in_ready is low here, so only the drain path exists.
                    if (out_xfer_s) begin
                        state_nxt_s      = FULL;
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        skid_clear_s     = 1'b1;
                    end else begin
                        state_nxt_s = SKID;
                    end
                end
`endif
                default: begin
                    state_nxt_s  = EMPTY;
                    main_clear_s = 1'b1;
`ifdef PIPE_REG_SKID_EN
                    skid_clear_s = 1'b1;
`endif
                end
            endcase
        end
    end

`ifdef PIPE_REG_SKID_EN
    // Main slot is refilled from skid while draining, otherwise from upstream.
    always_comb begin
        if (main_from_skid_s) begin
            main_din_s = skid_data_s;
        end else begin
            main_din_s = in_payload_s;
        end
    end
`else
    // Main slot is only ever filled from upstream.
    always_comb begin
        main_din_s = in_payload_s;
    end
`endif

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

`ifdef PIPE_REG_SKID_EN
    // Registered ready: high whenever the next state leaves the skid slot free.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r <= 1'b1;
        end else begin
            in_ready_r <= (beat_count(state_nxt_s) < 2'd2);
        end
    end
`endif

    pipe_slot #(
        .W (PW)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .load      (main_load_s),
        .clear     (main_clear_s),
        .load_data (main_din_s),
        .valid     (main_valid_s),
        .data      (main_data_s)
    );

`ifdef PIPE_REG_SKID_EN
    pipe_slot #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load_s),
        .clear     (skid_clear_s),
        .load_data (in_payload_s),
        .valid     (skid_valid_s),
        .data      (skid_data_s)
    );
`endif

    // Outputs are the main slot flops; an empty slot holds an all-zero payload.
    assign in_ready  = in_ready_s;
    assign out_valid = main_valid_s;
    assign out_data  = main_data_s[PW-1 -: DATA_W];
    assign out_rd    = main_data_s[CTRL_W +: RD_W];
    assign out_ctrl  = main_data_s[CTRL_W-1:0];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. The reference model is a plain
// FIFO queue with a capacity of 2 (skid build) or 1 (single-slot build).

module tb_pipe_stage_reg;

`ifdef PIPE_REG_SKID_EN
    localparam bit SKID_ON = 1'b1;
`else
    localparam bit SKID_ON = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] d;
        logic [4:0]  rd;
        logic [7:0]  c;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [4:0]  in_rd;
    logic [7:0]  in_ctrl;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic [7:0]  out_ctrl;

    int total = 0;
    int bad   = 0;

    beat_t q[$];

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rd     (in_rd),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_ctrl  (out_ctrl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare DUT outputs with the model at negedge, then advance
    // the model with the inputs sampled at the rising edge.
    task automatic cycle(input bit do_chk);
        beat_t head;
        logic  exp_v;
        logic  exp_rdy;
        logic  in_x;
        logic  out_x;
        beat_t nb;
        @(negedge clk);
        exp_v   = (q.size() > 0);
        head    = exp_v ? q[0] : '0;
        exp_rdy = SKID_ON ? (q.size() < 2) : ((q.size() == 0) || out_ready);
        if (do_chk) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
            chk("out_data",  out_data, head.d);
            chk("out_rd",    {59'd0, out_rd}, {59'd0, head.rd});
            chk("out_ctrl",  {56'd0, out_ctrl}, {56'd0, head.c});
            chk("in_ready",  {63'd0, in_ready}, {63'd0, exp_rdy});
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            in_x  = in_valid && exp_rdy;
            out_x = exp_v && out_ready;
            nb    = '{d: in_data, rd: in_rd, c: in_ctrl};
            if (out_x) void'(q.pop_front());
            if (in_x) q.push_back(nb);
            if (flush) q.delete();
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [63:0] d, input logic [7:0] c,
                         input bit ordy, input bit fl);
        in_valid  = v;
        in_data   = d;
        in_rd     = 5'($urandom_range(0, 31));
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        cycle(1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'hAAAA;
        in_rd     = 5'd3;
        in_ctrl   = 8'hFF;
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        // Reset held two cycles with a valid beat offered: it must be ignored.
        cycle(1'b0);
        cycle(1'b0);
        rst = 1'b0;
        drive(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

        // Streaming 1..8 with downstream always ready.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i), 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

        // Back-pressure: two beats while downstream stalls, then release.
        drive(1'b1, 64'h10, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 64'h11, 8'h22, 1'b0, 1'b0);
        drive(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

        // Flush from a full stage with a competing incoming beat 0x22.
        drive(1'b1, 64'h20, 8'h33, 1'b0, 1'b0);
        drive(1'b1, 64'h21, 8'h44, 1'b0, 1'b0);
        drive(1'b1, 64'h22, 8'h55, 1'b1, 1'b1);
        drive(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

        // Bubble: control asserted on idle input must never appear.
        for (int i = 0; i < 3; i++) drive(1'b0, 64'h5A, 8'hFF, 1'b1, 1'b0);
        drive(1'b1, 64'h77, 8'h05, 1'b1, 1'b0);
        drive(1'b0, 64'h0, 8'hFF, 1'b1, 1'b0);
        drive(1'b0, 64'h0, 8'hFF, 1'b1, 1'b0);

        // Reset mid-operation discards held beats.
        drive(1'b1, 64'h30, 8'h0C, 1'b0, 1'b0);
        drive(1'b1, 64'h31, 8'h0D, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 64'h32, 8'h0E, 1'b1, 1'b0);
        rst = 1'b0;
        drive(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive(($urandom_range(0, 3) != 0),
                  {$urandom, $urandom},
                  8'($urandom_range(0, 255)),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 15) == 0));
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
